// File: rtl/noc_demux_pkg.sv
// ============================================================================
// Module      : noc_demux_pkg
// Description : Shared definitions for the buffered NoC demultiplexer:
//               routing FSM state encoding, class field width and helpers
//               locating the first/last flag bits inside a flit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_demux_pkg;

    // Width of the traffic-class field carried in a header flit.
    localparam int CLASS_WIDTH = 3;

    // Routing FSM state encoding.
    typedef logic [1:0] demux_state_t;
    localparam demux_state_t IDLE  = 2'd0;
    localparam demux_state_t ROUTE = 2'd1;
    localparam demux_state_t DROP  = 2'd2;

    // Position of the "first flit of packet" flag.
    function automatic int first_bit(input int flit_width);
        return flit_width - 1;
    endfunction

    // Position of the "last flit of packet" flag.
    function automatic int last_bit(input int flit_width);
        return flit_width - 2;
    endfunction

endpackage : noc_demux_pkg

`default_nettype wire

// File: rtl/noc_demux_fifo.sv
// ============================================================================
// Module      : noc_demux_fifo
// Description : Per-channel output FIFO. Holds DEPTH entries in total: the
//               oldest entry sits in a dedicated output register, the rest
//               live in a circular buffer. A pushed flit never reaches the
//               output in the cycle it is written.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               i_wr_valid/o_wr_ready/i_wr_data - write side handshake
//               o_rd_valid/i_rd_ready/o_rd_data - read side handshake
//               o_full, o_empty  - occupancy flags (full is pre-pop)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_demux_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;      // total occupancy including the head
    logic [WIDTH-1:0] r_head;
    logic             r_head_valid;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_mem_nonempty;
    logic w_head_free;
    logic w_load_mem;
    logic w_load_push;
    logic w_mem_write;

    // Full is judged on the registered count only, so a pop in the same
    // cycle never frees a slot for the push; this keeps out_ready off the
    // in_ready path.
    assign w_full = (r_count == (PTR_W+1)'(DEPTH));
    assign w_push = i_wr_valid && !w_full;
    assign w_pop  = r_head_valid && i_rd_ready;

    // Entries in the circular buffer = count minus the head entry.
    assign w_mem_nonempty = (r_count > {{PTR_W{1'b0}}, r_head_valid});

    // The head refills from the buffer first (older data), otherwise
    // straight from the incoming flit when the buffer is empty.
    assign w_head_free = !r_head_valid || w_pop;
    assign w_load_mem  = w_head_free && w_mem_nonempty;
    assign w_load_push = w_head_free && !w_mem_nonempty && w_push;
    assign w_mem_write = w_push && !w_load_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_mem_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load_mem) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
            if (w_head_free) begin
                r_head_valid <= w_load_mem || w_load_push;
                if (w_load_mem) begin
                    r_head <= r_mem[r_rd_ptr];
                end else if (w_load_push) begin
                    r_head <= i_wr_data;
                end
            end
        end
    end

    // Storage array carries no reset; only entries counted as valid are read.
    always_ff @(posedge clk) begin
        if (w_mem_write) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_wr_ready = !w_full;
    assign o_rd_valid = r_head_valid;
    assign o_rd_data  = r_head;
    assign o_full     = w_full;
    assign o_empty    = !r_head_valid;

endmodule : noc_demux_fifo

`default_nettype wire

// File: rtl/noc_demux_buffered.sv
// ============================================================================
// Module      : noc_demux_buffered
// Description : Packet-aware 1-to-CHANNELS NoC demultiplexer with one FIFO
//               per output. The header flit's class selects an output via
//               the MAPPING table; the route is held until the last flit.
//               Packets of unmapped classes and orphan flits are discarded.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               in_flit/in_valid/in_ready   - input flit stream
//               out_flit/out_valid/out_ready - per-channel outputs (flat)
//               drop_count          - saturating discarded-flit counter
// Macro       : NOC_DEMUX_DROP_COUNT_EN - when defined drop_count counts
//               discarded flits; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_demux_buffered
    import noc_demux_pkg::*;
#(
    parameter int          FLIT_WIDTH   = 34,
    parameter int          CHANNELS     = 3,
    parameter logic [63:0] MAPPING      = 64'h0,
    parameter int          CLASS_LSB    = 24,
    parameter int          BUFFER_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FLIT_WIDTH-1:0]          in_flit,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [15:0]                    drop_count
);

    localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FIRST_BIT = first_bit(FLIT_WIDTH);
    localparam int LAST_BIT  = last_bit(FLIT_WIDTH);

    demux_state_t     r_state;
    logic [SEL_W-1:0] r_sel;

    logic [CLASS_WIDTH-1:0] w_cls;
    logic [7:0]             w_tgt;
    logic                   w_tgt_ok;
    logic [SEL_W-1:0]       w_tgt_idx;
    logic                   w_first;
    logic                   w_last;

    logic                w_ready;
    logic                w_accept;
    logic                w_push;
    logic [SEL_W-1:0]    w_push_sel;
    logic                w_drop;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_wr_ready;
    logic                w_unused;

    assign w_first   = in_flit[FIRST_BIT];
    assign w_last    = in_flit[LAST_BIT];
    assign w_cls     = in_flit[CLASS_LSB +: CLASS_WIDTH];
    assign w_tgt     = MAPPING[{w_cls, 3'b000} +: 8];
    assign w_tgt_ok  = (w_tgt < 8'(CHANNELS));
    assign w_tgt_idx = w_tgt[SEL_W-1:0];

    // Ready depends on in_flit only while IDLE (target lookup of a header);
    // it never looks at in_valid.
    always_comb begin
        w_ready    = 1'b0;
        w_push     = 1'b0;
        w_push_sel = r_sel;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_first && w_tgt_ok) begin
                    w_push_sel = w_tgt_idx;
                    w_ready    = !w_full[w_tgt_idx];
                    w_push     = in_valid && w_ready;
                end else begin
                    // Unmapped header or orphan flit: swallow it.
                    w_ready = 1'b1;
                    w_drop  = in_valid;
                end
            end
            ROUTE: begin
                w_ready = !w_full[r_sel];
                w_push  = in_valid && w_ready;
            end
            DROP: begin
                w_ready = 1'b1;
                w_drop  = in_valid;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign in_ready = w_ready && !rst;
    assign w_accept = in_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (w_first) begin
                        if (w_tgt_ok) begin
                            r_sel <= w_tgt_idx;
                            if (!w_last) begin
                                r_state <= ROUTE;
                            end
                        end else if (!w_last) begin
                            r_state <= DROP;
                        end
                    end
                end
                ROUTE, DROP: begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        noc_demux_fifo #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_wr_valid (w_push && (w_push_sel == SEL_W'(g))),
            .o_wr_ready (w_wr_ready[g]),
            .i_wr_data  (in_flit),
            .o_rd_valid (out_valid[g]),
            .i_rd_ready (out_ready[g]),
            .o_rd_data  (out_flit[g*FLIT_WIDTH +: FLIT_WIDTH]),
            .o_full     (w_full[g]),
            .o_empty    (w_empty[g])
        );
    end

`ifdef NOC_DEMUX_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= 16'h0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'h1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'h0;
`endif

    // Flags the top does not need; ready is derived from full directly.
    assign w_unused = &{1'b0, w_empty, w_wr_ready, w_drop};

endmodule : noc_demux_buffered

`default_nettype wire

// File: tb/tb_noc_demux_buffered.sv
// ============================================================================
// Module      : tb_noc_demux_buffered
// Description : Self-checking bench for noc_demux_buffered. A packet-level
//               reference model predicts routing, drops, FIFO occupancy and
//               in_ready; expected flits go into per-channel queues that an
//               independent monitor pops as outputs are delivered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_demux_buffered;

    localparam int          FW      = 34;
    localparam int          CH      = 3;
    localparam int          DEPTH   = 4;
    localparam int          CLS_LSB = 24;
    localparam logic [63:0] MAP     = 64'h02_01_00_05_FF_02_01_00;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FW-1:0]     in_flit = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH*FW-1:0]  out_flit;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready = '0;
    logic [15:0]       drop_count;

    noc_demux_buffered #(
        .FLIT_WIDTH   (FW),
        .CHANNELS     (CH),
        .MAPPING      (MAP),
        .CLASS_LSB    (CLS_LSB),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [FW-1:0] exp_q [CH][$];
    logic [FW-1:0] stim_q [$];
    int            occ [CH];
    int            cur      = -1;   // -1 idle, -2 dropping, else channel
    int            exp_drop = 0;
    int            rmode    = 0;    // 0 all ready, 1 random, 2 ch1 blocked
    logic [CH-1:0] prev_stall = '0;
    logic [FW-1:0] prev_flit [CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int tgt_of(input logic [FW-1:0] f);
        logic [63:0] m;
        logic [2:0]  c;
        m = MAP;
        c = f[CLS_LSB +: 3];
        return int'(m[c*8 +: 8]);
    endfunction

    function automatic logic [FW-1:0] mk(input bit first, input bit last, input int cls);
        logic [FW-1:0] f;
        f = {first, last, 32'($urandom)};
        f[CLS_LSB +: 3] = 3'(cls);
        return f;
    endfunction

    task automatic send_pkt(input int cls, input int len);
        for (int i = 0; i < len; i++) stim_q.push_back(mk(i == 0, i == len - 1, cls));
    endtask

    function automatic int exp_drop_vis();
`ifdef NOC_DEMUX_DROP_COUNT_EN
        return (exp_drop > 65535) ? 65535 : exp_drop;
`else
        return 0;
`endif
    endfunction

    function automatic bit model_ready(input logic [FW-1:0] f);
        int t;
        if (cur == -1) begin
            if (!f[FW-1]) return 1'b1;
            t = tgt_of(f);
            return (t < CH) ? (occ[t] < DEPTH) : 1'b1;
        end
        if (cur == -2) return 1'b1;
        return occ[cur] < DEPTH;
    endfunction

    task automatic model_accept(input logic [FW-1:0] f);
        int  t;
        bit  last;
        last = f[FW-2];
        if (cur == -1) begin
            if (f[FW-1]) begin
                t = tgt_of(f);
                if (t < CH) begin
                    exp_q[t].push_back(f);
                    occ[t]++;
                    if (!last) cur = t;
                end else begin
                    exp_drop++;
                    if (!last) cur = -2;
                end
            end else begin
                exp_drop++;
            end
        end else if (cur == -2) begin
            exp_drop++;
            if (last) cur = -1;
        end else begin
            exp_q[cur].push_back(f);
            occ[cur]++;
            if (last) cur = -1;
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            exp_q[c].delete();
            occ[c] = 0;
        end
        cur        = -1;
        exp_drop   = 0;
        prev_stall = '0;
    endtask

    // One clock: sample/check at negedge, drive new inputs after posedge.
    task automatic step();
        logic          acc;
        logic [CH-1:0] pops;
        @(negedge clk);
        for (int c = 0; c < CH; c++)
            chk("out_valid", 64'(out_valid[c]), 64'(occ[c] > 0));
        chk("drop_count", 64'(drop_count), 64'(exp_drop_vis()));
        if (in_valid) chk("in_ready", 64'(in_ready), 64'(model_ready(in_flit)));
        pops = out_valid & out_ready;
        acc  = in_valid && in_ready;
        if (acc) begin
            model_accept(in_flit);
            void'(stim_q.pop_front());
        end
        for (int c = 0; c < CH; c++) if (pops[c]) occ[c]--;
        @(posedge clk);
        #1;
        case (rmode)
            0: out_ready = '1;
            1: for (int c = 0; c < CH; c++) out_ready[c] = ($urandom_range(3) != 0);
            default: out_ready = 3'b101;
        endcase
        if (!(in_valid && !acc)) begin
            if (stim_q.size() > 0 && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_flit  = stim_q[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int b;
        b = budget;
        while (stim_q.size() != 0 && b > 0) begin
            step();
            b--;
        end
        if (stim_q.size() != 0) chk("stim_timeout", 64'(stim_q.size()), 64'd0);
    endtask

    task automatic drain();
        int b;
        int pend;
        rmode = 0;
        b     = 200;
        pend  = 1;
        while (pend != 0 && b > 0) begin
            step();
            b--;
            pend = 0;
            for (int c = 0; c < CH; c++) pend += exp_q[c].size();
        end
        for (int c = 0; c < CH; c++) chk("drain_empty", 64'(exp_q[c].size()), 64'd0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        for (int c = 0; c < CH; c++) chk("rst_out_flit", 64'(out_flit[c*FW +: FW]), 64'd0);
        model_clear();
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every delivered flit and checks
    // that a stalled output holds its value.
    always @(negedge clk) begin
        logic [FW-1:0] f;
        logic [FW-1:0] e;
        for (int c = 0; c < CH; c++) begin
            f = out_flit[c*FW +: FW];
            if (prev_stall[c]) begin
                chk("hold_valid", 64'(out_valid[c]), 64'd1);
                chk("hold_flit", 64'(f), 64'(prev_flit[c]));
            end
            if (out_valid[c] && out_ready[c]) begin
                if (exp_q[c].size() == 0) begin
                    chk("out_extra", 64'(out_valid[c]), 64'd0);
                end else begin
                    e = exp_q[c].pop_front();
                    chk("out_flit", 64'(f), 64'(e));
                end
            end
            prev_stall[c] = out_valid[c] && !out_ready[c] && !rst;
            prev_flit[c]  = f;
        end
    end

    initial begin
        for (int c = 0; c < CH; c++) occ[c] = 0;
        do_reset();

        // Three-flit class-1 packet, outputs always ready.
        rmode = 0;
        send_pkt(1, 3);
        run_until_idle(50);
        drain();

        // Single-flit class-2 packet, then an independent class-0 packet.
        send_pkt(2, 1);
        send_pkt(0, 2);
        run_until_idle(50);
        drain();

        // Class 3 unmapped (dropped), class 5 routed to channel 0, class 4 dropped.
        send_pkt(3, 4);
        send_pkt(5, 2);
        send_pkt(4, 1);
        run_until_idle(50);
        drain();

        // Channel 1 blocked: only DEPTH flits of a 6-flit packet get in.
        rmode = 2;
        send_pkt(1, 6);
        repeat (16) step();
        chk("blocked_left", 64'(stim_q.size()), 64'd2);
        rmode = 0;
        run_until_idle(50);
        drain();

        // Orphan flit then a normal header.
        stim_q.push_back(mk(1'b0, 1'b0, 1));
        send_pkt(0, 3);
        run_until_idle(50);
        drain();

        // Reset after 2 of 4 flits; the tail arrives as orphans.
        send_pkt(1, 4);
        begin
            int b;
            b = 50;
            while (stim_q.size() > 2 && b > 0) begin
                step();
                b--;
            end
            chk("pre_reset_accepts", 64'(stim_q.size()), 64'd2);
        end
        do_reset();
        send_pkt(2, 2);
        run_until_idle(50);
        drain();

        // Randomised traffic with random back-pressure.
        rmode = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(9) == 0) stim_q.push_back(mk(1'b0, 1'($urandom_range(1)), $urandom_range(7)));
            else send_pkt($urandom_range(7), $urandom_range(1, 5));
        end
        run_until_idle(20000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_noc_demux_buffered

`default_nettype wire
